// File: rtl/wish_pkg.sv
// Shared definitions for the wish_* Wishbone stream stages: tag bit positions
// and an elaboration-time clog2 helper.
package wish_pkg;

    localparam int TGC_FIRST = 0;
    localparam int TGC_LAST  = 1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wish_unpack.sv
// Wishbone stream width splitter: buffers one wide word and emits it as
// NUM_PACK narrow words, carrying first/last tags onto the edge slices.
module wish_unpack
    import wish_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           s_stb_i,
    input  logic                           s_cyc_i,
    input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
    input  logic [TGC_WIDTH-1:0]           s_tgc_i,
    output logic                           s_ack_o,
    output logic                           s_stall_o,
    output logic                           d_stb_o,
    output logic                           d_cyc_o,
    output logic [DATA_WIDTH-1:0]          d_dat_o,
    output logic [TGC_WIDTH-1:0]           d_tgc_o,
    input  logic                           d_ack_i
);

    localparam int WIDE_W = DATA_WIDTH * NUM_PACK;
    localparam int IDX_W  = (clog2(NUM_PACK) > 1) ? clog2(NUM_PACK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PACK - 1);

    logic [WIDE_W-1:0]     buffer_q;
    logic [TGC_WIDTH-1:0]  tgc_q;
    logic                  full_q;
    logic [IDX_W-1:0]      idx_q;

    logic                  is_last;
    logic                  accept;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] slice [NUM_PACK];

    assign is_last = (idx_q == LAST_IDX);
    assign xfer    = full_q & d_ack_i;

    // Stall drops in the cycle the final slice is acked, so the next wide
    // word loads with no idle cycle on the narrow side.
    assign s_stall_o = full_q & ~(d_ack_i & is_last);
    assign accept    = s_stb_i & s_cyc_i & ~s_stall_o;

    assign d_stb_o = full_q;
    assign d_cyc_o = full_q;

    // Slice i is the i-th narrow word in emission order.
    for (genvar i = 0; i < NUM_PACK; i++) begin : g_slice
        localparam int POS = (LITTLE_ENDIAN != 0) ? i : NUM_PACK - 1 - i;
        assign slice[i] = buffer_q[POS*DATA_WIDTH +: DATA_WIDTH];
    end

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        d_dat_o = '0;
        for (int i = 0; i < NUM_PACK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                d_dat_o = slice[i];
            end
        end
    end

    // First tag only on slice 0, last tag only on the final slice; user tags
    // ride on every slice. Tags read zero while nothing is being emitted.
    always_comb begin
        d_tgc_o = '0;
        if (full_q) begin
            d_tgc_o            = tgc_q;
            d_tgc_o[TGC_FIRST] = tgc_q[TGC_FIRST] & (idx_q == '0);
            d_tgc_o[TGC_LAST]  = tgc_q[TGC_LAST] & is_last;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the data buffer is reset too, so d_dat_o reads zero out of
            // reset instead of whatever the flops powered up with.
            buffer_q <= '0;
            tgc_q    <= '0;
            full_q   <= 1'b0;
            idx_q    <= '0;
            s_ack_o  <= 1'b0;
        end else begin
            s_ack_o <= accept;
            if (accept) begin
                buffer_q <= s_dat_i;
                tgc_q    <= s_tgc_i;
                full_q   <= 1'b1;
                idx_q    <= '0;
            end else if (xfer) begin
                if (is_last) begin
                    full_q <= 1'b0;
                    idx_q  <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wish_unpack.sv
// Directed bench for wish_unpack: default big-endian, little-endian and
// NUM_PACK=1 instances, each driven from its own scenario tasks.
module tb_wish_unpack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    // Default instance (big-endian, 4 x 8)
    logic        a_stb, a_cyc, a_ack, a_stall, a_dstb, a_dcyc, a_dack;
    logic [31:0] a_dat;
    logic [1:0]  a_tgc, a_dtgc;
    logic [7:0]  a_ddat;

    // Little-endian instance
    logic        l_stb, l_cyc, l_ack, l_stall, l_dstb, l_dcyc, l_dack;
    logic [31:0] l_dat;
    logic [1:0]  l_tgc, l_dtgc;
    logic [7:0]  l_ddat;

    // Single-slice instance
    logic        n_stb, n_cyc, n_ack, n_stall, n_dstb, n_dcyc, n_dack;
    logic [7:0]  n_dat;
    logic [1:0]  n_tgc, n_dtgc;
    logic [7:0]  n_ddat;

    wish_unpack dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_stb_i(a_stb), .s_cyc_i(a_cyc), .s_dat_i(a_dat), .s_tgc_i(a_tgc),
        .s_ack_o(a_ack), .s_stall_o(a_stall),
        .d_stb_o(a_dstb), .d_cyc_o(a_dcyc), .d_dat_o(a_ddat), .d_tgc_o(a_dtgc),
        .d_ack_i(a_dack)
    );

    wish_unpack #(.LITTLE_ENDIAN(1)) dut_le (
        .clk_i(clk), .rst_ni(rst_n),
        .s_stb_i(l_stb), .s_cyc_i(l_cyc), .s_dat_i(l_dat), .s_tgc_i(l_tgc),
        .s_ack_o(l_ack), .s_stall_o(l_stall),
        .d_stb_o(l_dstb), .d_cyc_o(l_dcyc), .d_dat_o(l_ddat), .d_tgc_o(l_dtgc),
        .d_ack_i(l_dack)
    );

    wish_unpack #(.DATA_WIDTH(8), .NUM_PACK(1)) dut_np1 (
        .clk_i(clk), .rst_ni(rst_n),
        .s_stb_i(n_stb), .s_cyc_i(n_cyc), .s_dat_i(n_dat), .s_tgc_i(n_tgc),
        .s_ack_o(n_ack), .s_stall_o(n_stall),
        .d_stb_o(n_dstb), .d_cyc_o(n_dcyc), .d_dat_o(n_ddat), .d_tgc_o(n_dtgc),
        .d_ack_i(n_dack)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({a_dstb, a_dcyc, a_ddat, a_dtgc, a_ack, a_stall} !== 14'h0)
            $display("FAIL reset_default: got %h expected 0",
                     {a_dstb, a_dcyc, a_ddat, a_dtgc, a_ack, a_stall});
        else passed++;
        total++;
        if ({l_dstb, l_dcyc, l_ddat, l_dtgc, l_ack, l_stall} !== 14'h0)
            $display("FAIL reset_le: got %h expected 0",
                     {l_dstb, l_dcyc, l_ddat, l_dtgc, l_ack, l_stall});
        else passed++;
        total++;
        if ({n_dstb, n_dcyc, n_ddat, n_dtgc, n_ack, n_stall} !== 14'h0)
            $display("FAIL reset_np1: got %h expected 0",
                     {n_dstb, n_dcyc, n_ddat, n_dtgc, n_ack, n_stall});
        else passed++;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_big_endian();
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] exp_t [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
        a_stb = 1'b1; a_cyc = 1'b1; a_dat = 32'h1122_3344; a_tgc = 2'b11; a_dack = 1'b1;
        #1;
        total++;
        if (a_stall !== 1'b0) $display("FAIL be_idle_stall: got %b expected 0", a_stall);
        else passed++;
        tick();
        a_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({a_dstb, a_dcyc, a_ddat, a_dtgc, a_ack} !== {2'b11, exp_d[i], exp_t[i], i == 0})
                $display("FAIL be_slice%0d: got stb=%b dat=%h tgc=%b ack=%b expected dat=%h tgc=%b ack=%b",
                         i, a_dstb, a_ddat, a_dtgc, a_ack, exp_d[i], exp_t[i], i == 0);
            else passed++;
            tick();
        end
        total++;
        if ({a_dstb, a_ack} !== 2'b00) $display("FAIL be_done: got stb/ack %b expected 00", {a_dstb, a_ack});
        else passed++;
    endtask

    task automatic test_little_endian();
        logic [7:0] exp_d [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        logic [1:0] exp_t [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
        l_stb = 1'b1; l_cyc = 1'b1; l_dat = 32'h1122_3344; l_tgc = 2'b11; l_dack = 1'b1;
        tick();
        l_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({l_dstb, l_ddat, l_dtgc, l_ack} !== {1'b1, exp_d[i], exp_t[i], i == 0})
                $display("FAIL le_slice%0d: got stb=%b dat=%h tgc=%b ack=%b expected dat=%h tgc=%b ack=%b",
                         i, l_dstb, l_ddat, l_dtgc, l_ack, exp_d[i], exp_t[i], i == 0);
            else passed++;
            tick();
        end
        total++;
        if (l_dstb !== 1'b0) $display("FAIL le_done: got stb %b expected 0", l_dstb);
        else passed++;
    endtask

    task automatic test_cyc_low();
        a_stb = 1'b1; a_cyc = 1'b0; a_dat = 32'hCAFE_F00D; a_tgc = 2'b11; a_dack = 1'b1;
        tick();
        tick();
        total++;
        if ({a_dstb, a_ack} !== 2'b00) $display("FAIL cyc_low_accept: got stb/ack %b expected 00", {a_dstb, a_ack});
        else passed++;
        a_stb = 1'b0; a_cyc = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        logic [1:0] exp_t [8] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        logic       exp_s [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_a [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        a_stb = 1'b1; a_dat = 32'hAABB_CCDD; a_tgc = 2'b01; a_dack = 1'b1;
        tick();
        a_dat = 32'h0102_0304; a_tgc = 2'b10;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) a_stb = 1'b0;
            #1;
            total++;
            if ({a_dstb, a_ddat, a_dtgc, a_stall, a_ack} !== {1'b1, exp_d[i], exp_t[i], exp_s[i], exp_a[i]})
                $display("FAIL b2b_word%0d: got stb=%b dat=%h tgc=%b stall=%b ack=%b expected dat=%h tgc=%b stall=%b ack=%b",
                         i, a_dstb, a_ddat, a_dtgc, a_stall, a_ack, exp_d[i], exp_t[i], exp_s[i], exp_a[i]);
            else passed++;
            tick();
        end
        total++;
        if (a_dstb !== 1'b0) $display("FAIL b2b_done: got stb %b expected 0", a_dstb);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic       ack_in [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       stb_in [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_d  [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
        logic       exp_s  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_a  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        a_stb = 1'b1; a_dat = 32'h1122_3344; a_tgc = 2'b00; a_dack = 1'b1;
        tick();
        a_dat = 32'hDEAD_BEEF;
        for (int i = 0; i < 7; i++) begin
            a_dack = ack_in[i];
            a_stb  = stb_in[i];
            #1;
            total++;
            if ({a_dstb, a_ddat, a_stall, a_ack} !== {1'b1, exp_d[i], exp_s[i], exp_a[i]})
                $display("FAIL bp_cycle%0d: got stb=%b dat=%h stall=%b ack=%b expected dat=%h stall=%b ack=%b",
                         i, a_dstb, a_ddat, a_stall, a_ack, exp_d[i], exp_s[i], exp_a[i]);
            else passed++;
            tick();
        end
        total++;
        if ({a_dstb, a_ack} !== 2'b00) $display("FAIL bp_done: got stb/ack %b expected 00", {a_dstb, a_ack});
        else passed++;
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_d [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
        logic [1:0] exp_t [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
        a_stb = 1'b1; a_dat = 32'h1122_3344; a_tgc = 2'b11; a_dack = 1'b1;
        tick();
        a_stb = 1'b0;
        tick();
        total++;
        if (a_ddat !== 8'h22) $display("FAIL rst_pre: got dat %h expected 22", a_ddat);
        else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_dstb, a_dcyc, a_ddat, a_dtgc, a_ack, a_stall} !== 14'h0)
            $display("FAIL rst_async: got %h expected 0", {a_dstb, a_dcyc, a_ddat, a_dtgc, a_ack, a_stall});
        else passed++;
        tick();
        tick();
        total++;
        if ({a_dstb, a_ack} !== 2'b00) $display("FAIL rst_held: got stb/ack %b expected 00", {a_dstb, a_ack});
        else passed++;
        rst_n = 1'b1;
        a_stb = 1'b1; a_dat = 32'h5566_7788; a_tgc = 2'b11;
        tick();
        a_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({a_dstb, a_ddat, a_dtgc} !== {1'b1, exp_d[i], exp_t[i]})
                $display("FAIL rst_after_slice%0d: got stb=%b dat=%h tgc=%b expected dat=%h tgc=%b",
                         i, a_dstb, a_ddat, a_dtgc, exp_d[i], exp_t[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_num_pack_one();
        n_stb = 1'b1; n_cyc = 1'b1; n_dat = 8'h5A; n_tgc = 2'b11; n_dack = 1'b1;
        #1;
        total++;
        if (n_stall !== 1'b0) $display("FAIL np1_idle_stall: got %b expected 0", n_stall);
        else passed++;
        tick();
        n_dat = 8'hA5; n_tgc = 2'b00;
        #1;
        total++;
        if ({n_dstb, n_ddat, n_dtgc, n_ack, n_stall} !== {1'b1, 8'h5A, 2'b11, 1'b1, 1'b0})
            $display("FAIL np1_word0: got stb=%b dat=%h tgc=%b ack=%b stall=%b expected 1 5a 11 1 0",
                     n_dstb, n_ddat, n_dtgc, n_ack, n_stall);
        else passed++;
        tick();
        n_stb = 1'b0;
        #1;
        total++;
        if ({n_dstb, n_ddat, n_dtgc, n_ack, n_stall} !== {1'b1, 8'hA5, 2'b00, 1'b1, 1'b0})
            $display("FAIL np1_word1: got stb=%b dat=%h tgc=%b ack=%b stall=%b expected 1 a5 00 1 0",
                     n_dstb, n_ddat, n_dtgc, n_ack, n_stall);
        else passed++;
        tick();
        total++;
        if ({n_dstb, n_ack} !== 2'b00) $display("FAIL np1_done: got stb/ack %b expected 00", {n_dstb, n_ack});
        else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_stb = 1'b0; a_cyc = 1'b0; a_dat = '0; a_tgc = '0; a_dack = 1'b0;
        l_stb = 1'b0; l_cyc = 1'b0; l_dat = '0; l_tgc = '0; l_dack = 1'b0;
        n_stb = 1'b0; n_cyc = 1'b0; n_dat = '0; n_tgc = '0; n_dack = 1'b0;
        test_reset();
        test_big_endian();
        test_little_endian();
        test_cyc_low();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_num_pack_one();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
